// File: rtl/conv_layer_param_if.sv
// Stream, weight/bias load and result signals of conv_layer_param.
// master drives pixels and coefficients; slave is the convolution core.
interface conv_layer_param_if #(
  parameter int K           = 5,
  parameter int IN_CH       = 3,
  parameter int OUT_CH      = 3,
  parameter int DATA_BITS   = 12,
  parameter int WEIGHT_BITS = 8
);
  localparam int NW      = OUT_CH*IN_CH*K*K;
  localparam int WA_BITS = (NW > 1) ? $clog2(NW) : 1;
  localparam int BA_BITS = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  logic                          valid_in;
  logic [IN_CH*DATA_BITS-1:0]    data_in;
  logic                          w_we;
  logic [WA_BITS-1:0]            w_addr;
  logic [WEIGHT_BITS-1:0]        w_data;
  logic                          b_we;
  logic [BA_BITS-1:0]            b_addr;
  logic [WEIGHT_BITS-1:0]        b_data;
  logic [OUT_CH*DATA_BITS-1:0]   data_out;
  logic                          valid_out;
  logic                          last_out;
  logic                          busy;

  modport master (
    output valid_in, data_in, w_we, w_addr, w_data, b_we, b_addr, b_data,
    input  data_out, valid_out, last_out, busy
  );
  modport slave (
    input  valid_in, data_in, w_we, w_addr, w_data, b_we, b_addr, b_data,
    output data_out, valid_out, last_out, busy
  );
endinterface

// File: rtl/conv_layer_param.sv
// Streaming valid-mode KxK multi-channel convolution, 3-stage pipeline with saturation.
// Define CONV_LAYER_RELU_EN to clamp negative results to zero.
module conv_layer_param #(
  parameter int WIDTH       = 12,
  parameter int HEIGHT      = 12,
  parameter int K           = 5,
  parameter int IN_CH       = 3,
  parameter int OUT_CH      = 3,
  parameter int DATA_BITS   = 12,
  parameter int WEIGHT_BITS = 8,
  parameter int SHIFT       = 1
) (
  input logic            clk,
  input logic            rst,
  conv_layer_param_if.slave io
);
  localparam int LB_LEN    = (K-1)*WIDTH + K;
  localparam int TAPS      = IN_CH*K*K;
  localparam int NW        = OUT_CH*TAPS;
  localparam int PROD_BITS = DATA_BITS + WEIGHT_BITS;
  localparam int ACC_BITS  = PROD_BITS + $clog2(TAPS);
  localparam int RES_BITS  = ACC_BITS + 1;
  localparam int STAGES    = 3;
  localparam int CW        = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_FIRST = CW'(K-1);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH-1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K-1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT-1);
  localparam logic signed [RES_BITS-1:0] SAT_MAX = RES_BITS'((1 <<< (DATA_BITS-1)) - 1);
  localparam logic signed [RES_BITS-1:0] SAT_MIN = ~SAT_MAX;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept, win_vld, win_last, busy;
  logic [STAGES:1] vld_pipe, last_pipe;

  logic signed [DATA_BITS-1:0]   lb     [IN_CH][LB_LEN];
  logic signed [DATA_BITS-1:0]   lb_nxt [IN_CH][LB_LEN];
  logic signed [WEIGHT_BITS-1:0] w_mem  [NW];
  logic signed [WEIGHT_BITS-1:0] b_mem  [OUT_CH];
  logic signed [PROD_BITS-1:0]   prod_nxt [NW];
  logic signed [PROD_BITS-1:0]   prod     [NW];
  logic signed [ACC_BITS-1:0]    acc_nxt  [OUT_CH];
  logic signed [ACC_BITS-1:0]    acc      [OUT_CH];
  logic signed [DATA_BITS-1:0]   res_ch   [OUT_CH];
  logic [OUT_CH*DATA_BITS-1:0]   dout;

  assign accept   = io.valid_in;
  assign win_vld  = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign win_last = accept && (row == ROW_LAST) && (col == COL_LAST);
  assign busy     = (row != '0) || (col != '0) || (|vld_pipe);

  // Buffer contents as they will be after this pixel shifts in; index 0 is the newest pixel,
  // so the window is read without waiting a cycle for the shift.
  always_comb begin
    for (int i = 0; i < IN_CH; i++) begin
      lb_nxt[i][0] = io.data_in[i*DATA_BITS +: DATA_BITS];
      for (int j = 1; j < LB_LEN; j++) lb_nxt[i][j] = lb[i][j-1];
    end
  end

  always_comb begin
    for (int o = 0; o < OUT_CH; o++)
      for (int i = 0; i < IN_CH; i++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            prod_nxt[((o*IN_CH+i)*K+ky)*K+kx] =
              PROD_BITS'(lb_nxt[i][(K-1-ky)*WIDTH + (K-1-kx)]) *
              PROD_BITS'(w_mem[((o*IN_CH+i)*K+ky)*K+kx]);
  end

  always_comb begin
    for (int o = 0; o < OUT_CH; o++) begin
      acc_nxt[o] = '0;
      for (int t = 0; t < TAPS; t++) acc_nxt[o] = acc_nxt[o] + ACC_BITS'(prod[o*TAPS+t]);
    end
  end

  for (genvar o = 0; o < OUT_CH; o++) begin : g_out
    logic signed [RES_BITS-1:0]  res;
    logic signed [DATA_BITS-1:0] sat;
    always_comb begin
      res = RES_BITS'(acc[o] >>> SHIFT) + RES_BITS'(b_mem[o]);
      if (res > SAT_MAX)      sat = SAT_MAX[DATA_BITS-1:0];
      else if (res < SAT_MIN) sat = SAT_MIN[DATA_BITS-1:0];
      else                    sat = res[DATA_BITS-1:0];
`ifdef CONV_LAYER_RELU_EN
      if (sat[DATA_BITS-1]) sat = '0;
`endif
    end
    assign res_ch[o] = sat;
  end

  // Arithmetic stages carry no reset: their contents only matter under a set valid bit.
  always_ff @(posedge clk) begin
    prod <= prod_nxt;
    acc  <= acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      dout      <= '0;
      for (int i = 0; i < IN_CH; i++)
        for (int j = 0; j < LB_LEN; j++) lb[i][j] <= '0;
      for (int n = 0; n < NW; n++)     w_mem[n] <= '0;
      for (int o = 0; o < OUT_CH; o++) b_mem[o] <= '0;
    end else begin
      if (accept) begin
        lb <= lb_nxt;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Coefficients may only change between frames so a frame never mixes weight sets.
      if (io.w_we && !busy && (int'(io.w_addr) < NW))     w_mem[io.w_addr] <= io.w_data;
      if (io.b_we && !busy && (int'(io.b_addr) < OUT_CH)) b_mem[io.b_addr] <= io.b_data;
      vld_pipe  <= {vld_pipe[STAGES-1:1], win_vld};
      last_pipe <= {last_pipe[STAGES-1:1], win_last};
      if (vld_pipe[STAGES-1])
        for (int o = 0; o < OUT_CH; o++) dout[o*DATA_BITS +: DATA_BITS] <= res_ch[o];
    end
  end

  assign io.data_out  = dout;
  assign io.valid_out = vld_pipe[STAGES];
  assign io.last_out  = last_pipe[STAGES];
  assign io.busy      = busy;
endmodule

// File: doc/conv_layer_param.md
CONV_LAYER_PARAM -- requirements
Module: conv_layer_param

Interface
REQ-001 SHALL have parameters: WIDTH=12 (image columns); HEIGHT=12 (image rows); K=5 (square kernel size); IN_CH=3 (input channels); OUT_CH=3 (output channels); DATA_BITS=12 (signed pixel width); WEIGHT_BITS=8 (signed weight and bias width); SHIFT=1 (right shift applied to the accumulator before the bias add).
REQ-002 SHALL use one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have these stream ports: valid_in  in  1  input pixel strobe; data_in  in  IN_CH*DATA_BITS  one signed pixel per channel, channel 0 in the LSBs.
REQ-004 SHALL have these weight-load ports: w_we  in  1  weight write strobe; w_addr  in  clog2(OUT_CH*IN_CH*K*K)  index ((o*IN_CH+i)*K+ky)*K+kx; w_data  in  WEIGHT_BITS  signed weight.
REQ-005 SHALL have these bias-load ports: b_we  in  1  bias write strobe; b_addr  in  clog2(OUT_CH) (minimum 1 bit)  output-channel index; b_data  in  WEIGHT_BITS  signed bias.
REQ-006 SHALL have these outputs: data_out  out  OUT_CH*DATA_BITS  signed results, channel 0 in the LSBs; valid_out  out  1  result strobe; last_out  out  1  marks the final result of a frame; busy  out  1  a frame or its pipeline is in flight.

Function
REQ-007 SHALL accept pixels in raster order, one pixel per cycle in which valid_in=1; a frame is WIDTH*HEIGHT accepted pixels; cycles with valid_in=0 are gaps that advance no counter or window.
REQ-008 SHALL keep a per-channel line buffer of (K-1)*WIDTH+K entries that shifts only on an accepted pixel.
REQ-009 SHALL form one window per accepted pixel at (row r, col c) with r>=K-1 and c>=K-1; window position ky=0 is the oldest row and kx=0 the oldest column. This is valid-mode convolution: no padding, (HEIGHT-K+1)*(WIDTH-K+1) windows per frame.
REQ-010 SHALL wrap the column counter at WIDTH-1 and the row counter at HEIGHT-1; both return to 0 after the last pixel; the next accepted pixel starts a new frame with no idle cycle required.
REQ-011 SHALL compute, per output channel o, acc = sum over i, ky, kx of pixel*weight[o][i][ky][kx], with full signed precision (DATA_BITS+WEIGHT_BITS+clog2(IN_CH*K*K) bits).
REQ-012 SHALL then compute res = (acc >>> SHIFT) + sign-extended bias[o], and saturate res to signed DATA_BITS: above 2^(DATA_BITS-1)-1 gives the maximum; below -2^(DATA_BITS-1) gives the minimum.
REQ-013 SHALL be a 3-stage pipeline: products registered, then sum registered, then bias/shift/saturate registered; valid_out rises exactly 3 cycles after the window-completing valid_in cycle, independent of gaps.
REQ-014 SHALL hold data_out between results; data_out is meaningful only while valid_out=1.
REQ-015 SHALL assert last_out together with valid_out for the window of pixel (HEIGHT-1, WIDTH-1) only.
REQ-016 SHALL drive busy=1 while the frame pixel count is nonzero or any pipeline stage holds a valid result.
REQ-017 SHALL apply w_we/b_we writes only when busy=0 and ignore them otherwise; a write takes effect on the next cycle.
REQ-018 SHALL let the stream start on the same cycle as a write: a valid_in coinciding with w_we or b_we uses the pre-write weights.

Reset
REQ-019 SHALL, while rst=1, clear the counters, line buffers, pipeline valids, all weights and all biases to 0, and drive data_out=0, valid_out=0, last_out=0, busy=0.
REQ-020 SHALL abandon a partial frame when reset is asserted mid-frame; the first accepted pixel after rst deasserts is pixel (0,0).

Configuration
REQ-021 SHALL, when the macro CONV_LAYER_RELU_EN is defined, clamp negative saturated results to 0 per channel, without adding any latency; when the macro is undefined, SHALL output the signed saturated results unchanged.

Verification (W=H=6, K=3, IN_CH=2, OUT_CH=2, DATA_BITS=12, WEIGHT_BITS=8, SHIFT=1)
REQ-022 All weights 0, bias[0]=5, bias[1]=-3, one full frame -> 16 outputs, ch0=5, ch1=-3 (0xFFD; 0 with RELU_EN), last_out on the 16th output only.
REQ-023 Ch0 pixel = raster index n, weight[0][0][1][1]=2, all others 0 -> output ch0 sequence 7,8,9,10,13,...,28; the first output appears 3 cycles after pixel n=14 is accepted.
REQ-024 All pixels 2047, all weights 127 -> every output 2047; all pixels -2048 -> -2048 (0 with RELU_EN).
REQ-025 Same frame as REQ-023 with random 0-3 cycle valid_in gaps -> identical values and count, and each output exactly 3 cycles after its completing pixel.
REQ-026 rst asserted after 20 pixels, then a full frame -> exactly 16 outputs matching REQ-023.
REQ-027 w_we asserted while busy=1 -> weight unchanged; the same write with busy=0 -> applied, visible in the next frame.
